// File: rtl/regfile_debug_ctrl.sv
// rtl/regfile_debug_ctrl.sv - debug halt/resume sequencer with register-file access port
// Drains and stops the core, then serves valid/ready register reads and writes.
module regfile_debug_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int HALT_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  output logic              core_run,
  output logic              core_halt_req,
  input  logic              core_idle,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume_req,
  output logic              dbg_halted,
  output logic              dbg_halt_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  output logic              rf_dbg_sel,
  output logic              rf_run,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {RUNNING, HALTING, HALTED, ACCESS, RESPOND} state_t;

  state_t              state;
  logic [CNT_W-1:0]    halt_cnt;
  logic                halt_err;
  logic                pending_resume;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                in_access;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= RUNNING;
      halt_cnt       <= '0;
      halt_err       <= 1'b0;
      pending_resume <= 1'b0;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          if (dbg_halt_req) begin
            state    <= HALTING;
            halt_err <= 1'b0;
            halt_cnt <= '0;
          end
        end
        HALTING: begin
          // An idle core on the last counted cycle still halts cleanly.
          if (core_idle) begin
            state <= HALTED;
          end else if (halt_cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
            state    <= RUNNING;
            halt_err <= 1'b1;
          end else begin
            halt_cnt <= halt_cnt + 1'b1;
          end
        end
        HALTED: begin
          if (dbg_req_valid) begin
            state     <= ACCESS;
            req_we    <= dbg_req_we;
            req_addr  <= dbg_req_addr;
            req_wdata <= dbg_req_wdata;
            if (dbg_resume_req) pending_resume <= 1'b1;
          end else if (dbg_resume_req || pending_resume) begin
            state          <= RUNNING;
            pending_resume <= 1'b0;
          end
        end
        ACCESS: begin
          state     <= RESPOND;
          rsp_err   <= req_we && (req_addr == '0);
          rsp_rdata <= (!req_we && (req_addr != '0)) ? rf_rdata : '0;
          if (dbg_resume_req) pending_resume <= 1'b1;
        end
        RESPOND: begin
          if (dbg_resume_req) pending_resume <= 1'b1;
          if (dbg_rsp_ready) state <= HALTED;
        end
        default: state <= RUNNING;
      endcase
    end
  end

  assign in_access     = (state == ACCESS);
  assign core_run      = run_en && ((state == RUNNING) || (state == HALTING));
  assign core_halt_req = (state == HALTING);
  assign rf_dbg_sel    = (state == HALTED) || (state == ACCESS) || (state == RESPOND);
  assign dbg_halted    = rf_dbg_sel;
  assign dbg_halt_err  = halt_err;
  assign dbg_req_ready = (state == HALTED);
  assign dbg_rsp_valid = (state == RESPOND);
  assign dbg_rsp_rdata = rsp_rdata;
  assign dbg_rsp_err   = rsp_err;

  // x0 is hardwired, so a write there never reaches the register file.
  assign rf_we    = in_access && req_we && (req_addr != '0);
  assign rf_run   = rf_we;
  assign rf_raddr = in_access ? req_addr : '0;
  assign rf_waddr = in_access ? req_addr : '0;
  assign rf_wdata = in_access ? req_wdata : '0;

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// tb/tb_regfile_debug_ctrl.sv - scoreboard bench for regfile_debug_ctrl
module tb_regfile_debug_ctrl;

  logic        clk;
  logic        reset;
  logic        run_en;
  logic        core_run;
  logic        core_halt_req;
  logic        core_idle;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_halted;
  logic        dbg_halt_err;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic        dbg_rsp_err;
  logic        rf_dbg_sel;
  logic        rf_run;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_debug_ctrl #(.DATA_W(32), .ADDR_W(5), .HALT_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .core_run(core_run),
    .core_halt_req(core_halt_req), .core_idle(core_idle),
    .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
    .dbg_halted(dbg_halted), .dbg_halt_err(dbg_halt_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
    .rf_dbg_sel(rf_dbg_sel), .rf_run(rf_run), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the core top would provide; x0 deliberately returns junk.
  logic [31:0] rf_mem [32];
  bit          rf_init_done = 1'b0;
  always @(posedge clk) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
      rf_init_done <= 1'b1;
    end else if (rf_dbg_sel && rf_we && rf_run) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'hBAD0BAD0 : rf_mem[rf_raddr];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model_regs [32];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is checked against the oldest expectation.
  always @(negedge clk) begin
    if (reset && dbg_rsp_valid && dbg_rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", dbg_rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, dbg_rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic halt();
    dbg_halt_req = 1'b1;
    tick();
    dbg_halt_req = 1'b0;
    chk("halting_req", {31'd0, core_halt_req}, 32'd1);
    chk("halting_err_clr", {31'd0, dbg_halt_err}, 32'd0);
    tick();
    chk("halted", {31'd0, dbg_halted}, 32'd1);
    chk("halted_core_run", {31'd0, core_run}, 32'd0);
    chk("halted_ready", {31'd0, dbg_req_ready}, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic resume);
    rsp_t e;
    dbg_req_valid  = 1'b1;
    dbg_req_we     = we;
    dbg_req_addr   = addr;
    dbg_req_wdata  = data;
    dbg_resume_req = resume;
    tick();
    dbg_req_valid  = 1'b0;
    dbg_resume_req = 1'b0;
    chk("acc_rf_we", {31'd0, rf_we}, {31'd0, we && addr != 5'd0});
    chk("acc_rf_run", {31'd0, rf_run}, {31'd0, we && addr != 5'd0});
    chk("acc_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    if (we) begin
      chk("acc_rf_waddr", {27'd0, rf_waddr}, {27'd0, addr});
      chk("acc_rf_wdata", rf_wdata, data);
    end
    e.err   = we && (addr == 5'd0);
    e.rdata = (we || addr == 5'd0) ? 32'd0 : model_regs[addr];
    exp_q.push_back(e);
    if (we && addr != 5'd0) model_regs[addr] = data;
  endtask

  task automatic finish_rsp(input int stall, input logic resume);
    logic [31:0] held;
    logic        held_err;
    dbg_rsp_ready = (stall == 0);
    tick();
    chk("rsp_latency", {31'd0, dbg_rsp_valid}, 32'd1);
    held     = dbg_rsp_rdata;
    held_err = dbg_rsp_err;
    for (int s = 0; s < stall; s++) begin
      dbg_resume_req = resume && (s == 0);
      tick();
      dbg_resume_req = 1'b0;
      chk("rsp_hold_valid", {31'd0, dbg_rsp_valid}, 32'd1);
      chk("rsp_hold_rdata", dbg_rsp_rdata, held);
      chk("rsp_hold_err", {31'd0, dbg_rsp_err}, {31'd0, held_err});
    end
    dbg_rsp_ready = 1'b1;
    tick();
    chk("back_to_halted", {31'd0, dbg_req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b0; run_en = 1'b1; core_idle = 1'b1;
    dbg_halt_req = 1'b0; dbg_resume_req = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    dbg_rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    do_reset();
    chk("rst_halted", {31'd0, dbg_halted}, 32'd0);
    chk("rst_core_run", {31'd0, core_run}, 32'd1);
    chk("rst_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    chk("rst_halt_err", {31'd0, dbg_halt_err}, 32'd0);
    chk("rst_ready", {31'd0, dbg_req_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);

    run_en = 1'b0;
    #1 chk("run_en_off", {31'd0, core_run}, 32'd0);
    run_en = 1'b1;
    dbg_resume_req = 1'b1;
    tick();
    dbg_resume_req = 1'b0;
    chk("resume_in_running", {31'd0, dbg_halted | core_halt_req}, 32'd0);

    halt();
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    finish_rsp(0, 1'b0);
    issue(1'b0, 5'd5, 32'h0, 1'b0);
    finish_rsp(0, 1'b0);
    issue(1'b1, 5'd0, 32'h00001234, 1'b0);
    finish_rsp(1, 1'b0);
    issue(1'b0, 5'd0, 32'h0, 1'b0);
    finish_rsp(0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      finish_rsp($urandom_range(0, 2), 1'b0);
    end

    // Resume held pending behind a stalled response.
    issue(1'b0, 5'd5, 32'h0, 1'b0);
    finish_rsp(5, 1'b1);
    chk("pend_halted_cycle", {31'd0, dbg_halted}, 32'd1);
    chk("pend_core_run_off", {31'd0, core_run}, 32'd0);
    tick();
    chk("pend_resumed", {31'd0, dbg_halted}, 32'd0);
    chk("pend_core_run", {31'd0, core_run}, 32'd1);

    // Request beats a same-cycle resume, which then fires after the response.
    halt();
    issue(1'b1, 5'd9, 32'hCAFEF00D, 1'b1);
    finish_rsp(0, 1'b0);
    tick();
    chk("req_prio_resumed", {31'd0, dbg_halted}, 32'd0);

    // Halt timeout.
    core_idle = 1'b0;
    dbg_halt_req = 1'b1;
    tick();
    dbg_halt_req = 1'b0;
    n = 0;
    while (core_halt_req && n < 50) begin
      n++;
      tick();
    end
    chk("timeout_cycles", n, 32'd8);
    chk("timeout_err", {31'd0, dbg_halt_err}, 32'd1);
    chk("timeout_running", {31'd0, dbg_halted}, 32'd0);
    core_idle = 1'b1;
    halt();

    // Reset in the middle of a write access, with a resume pending.
    issue(1'b1, 5'd7, 32'h0BADC0DE, 1'b0);
    reset = 1'b0;
    dbg_resume_req = 1'b1;
    tick();
    reset = 1'b1;
    dbg_resume_req = 1'b0;
    exp_q.delete();
    chk("rsta_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
    chk("rsta_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rsta_halted", {31'd0, dbg_halted}, 32'd0);
    chk("rsta_core_run", {31'd0, core_run}, 32'd1);
    halt();
    tick();
    tick();
    chk("rsta_no_pending", {31'd0, dbg_halted}, 32'd1);
    issue(1'b0, 5'd7, 32'h0, 1'b0);
    finish_rsp(0, 1'b0);

    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_debug_ctrl.md
Name: regfile_debug_ctrl

Overview:
- Debug access sequencer for the 32x32 integer register file.
- Handles halt requests: asks the core to drain, stops it, then takes over the register-file ports so a debug host can read and write x0–x31 through a valid/ready request/response pair. Resumes the core on request.
- Sits between the debug transport and the core top. The top muxes the register-file read port B, the write port and the register-file run input to this block's rf_* outputs whenever rf_dbg_sel=1.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- HALT_TIMEOUT, 256, maximum cycles spent in HALTING waiting for core_idle

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- run_en  in  1  top-level run enable
- core_run  out  1  run to core pipeline
- core_halt_req  out  1  tells core to stop fetching and drain
- core_idle  in  1  core pipeline empty, safe to stop
- dbg_halt_req  in  1  halt request pulse
- dbg_resume_req  in  1  resume request pulse
- dbg_halted  out  1  core halted, debug owns the register file
- dbg_halt_err  out  1  sticky: last halt attempt timed out
- dbg_req_valid  in  1  access request valid
- dbg_req_ready  out  1  access request ready
- dbg_req_we  in  1  1=write, 0=read
- dbg_req_addr  in  ADDR_W  register index
- dbg_req_wdata  in  DATA_W  write data
- dbg_rsp_valid  out  1  response valid
- dbg_rsp_ready  in  1  response accepted
- dbg_rsp_rdata  out  DATA_W  read data (0 for writes)
- dbg_rsp_err  out  1  write to x0 attempted
- rf_dbg_sel  out  1  top muxes register-file ports to this block
- rf_run  out  1  register-file run input while rf_dbg_sel=1
- rf_raddr  out  ADDR_W  register-file read address (port B)
- rf_rdata  in  DATA_W  register-file combinational read data (port B)
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

Behaviour:
- States: RUNNING, HALTING, HALTED, ACCESS, RESPOND.
- Reset (reset=0 at a clk edge):
  - State goes to RUNNING.
  - Response, error flag and pending-resume flag are cleared.
  - Captured request and response registers are zeroed.
  - Reset mid-access abandons the access. Any outstanding response is dropped.
- Output decodes:
  - core_run = run_en & (RUNNING | HALTING).
  - core_halt_req = HALTING.
  - dbg_halted = rf_dbg_sel = HALTED | ACCESS | RESPOND.
- RUNNING:
  - dbg_halt_req moves to HALTING.
  - dbg_halt_err clears and the timeout counter loads 0.
  - dbg_resume_req is ignored.
- HALTING:
  - If core_idle=1, go to HALTED next cycle; core_run is 0 from that cycle.
  - Otherwise the counter increments. When the counter equals HALT_TIMEOUT-1 and core_idle is still 0, go to RUNNING and set dbg_halt_err.
  - core_idle wins over the timeout on the same cycle.
  - dbg_halt_req is ignored here.
- HALTED:
  - dbg_req_ready=1 only in this state.
  - If dbg_req_valid=1, capture we/addr/wdata and go to ACCESS.
  - Else, if dbg_resume_req=1 or pending_resume=1, go to RUNNING and clear pending_resume.
  - A request takes priority over a resume on the same cycle; that resume is latched as pending.
- ACCESS (exactly 1 cycle):
  - rf_raddr = rf_waddr = captured addr; rf_wdata = captured wdata.
  - Write, addr!=0: rf_we=1 and rf_run=1.
  - Write to x0: rf_we=0, err=1.
  - Read: capture rf_rdata into dbg_rsp_rdata. Read of x0 returns 0.
  - Next state is RESPOND.
- RESPOND:
  - dbg_rsp_valid=1; data and err are held stable until dbg_rsp_ready=1, then go to HALTED.
  - dbg_rsp_rdata=0 for writes.
- Outside ACCESS: rf_we=0, rf_run=0, rf_raddr/rf_waddr/rf_wdata=0.
- dbg_resume_req in ACCESS or RESPOND sets pending_resume. It takes effect on the first HALTED cycle that has no valid request.
- Latency:
  - Request accept (cycle N) to register-file write or capture: N+1.
  - Response first valid: N+2.
  - Back-to-back accesses: one per 3 cycles when dbg_rsp_ready is held at 1.
- run_en=0 in RUNNING or HALTING:
  - core_run=0 while the state is kept.
  - HALTING still waits for core_idle or the timeout.

Test Plan:
- Basic halt: core_idle=1, pulse dbg_halt_req -> HALTING 1 cycle, dbg_halted=1 and core_run=0 on the following cycle.
- Write then read back: write x5=0xDEADBEEF, then read x5 -> rf_we pulse with rf_waddr=5 and rf_run=1 in ACCESS. Read response has rdata=0xDEADBEEF, err=0, valid 2 cycles after accept.
- x0 handling: write x0=0x1234 -> rf_we stays 0, err=1. Read x0 -> rdata=0, err=0.
- Halt timeout: HALT_TIMEOUT=8, core_idle held 0 -> RUNNING after 8 HALTING cycles with dbg_halt_err=1. The next dbg_halt_req clears it.
- Resume during RESPOND: hold dbg_rsp_ready=0 for 5 cycles and pulse dbg_resume_req -> response stays stable. After the response is accepted, one HALTED cycle, then RUNNING with core_run=run_en.
- Reset in ACCESS: assert reset=0 during a write access -> the next cycle is RUNNING with dbg_rsp_valid=0, rf_we=0, dbg_halted=0 and no pending resume.
